pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V core; successor to the fixed 32-bit PC register/+4 counter.
- Holds the architectural PC and advances it sequentially.
- Also handles: fetch backpressure, pipeline stall, branch/jump redirect, trap entry with a saved EPC, mret return, and a halt/resume state machine.
- Sits between the control unit/branch logic and the instruction-memory address port.

Parameters:
- XLEN, 32, PC/address width in bits (min 8).
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry (truncated to XLEN).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- fetch_ready  input  1  imem accepts current pc this cycle
- stall  input  1  pipeline stall; hold pc
- redirect_valid  input  1  branch/jump taken
- redirect_target  input  XLEN  branch/jump destination
- trap_req  input  1  external/illegal-instruction trap request
- mret  input  1  return from trap
- halt_req  input  1  request halt
- resume  input  1  leave halt
- pc  output  XLEN  current fetch address
- pc_plus  output  XLEN  pc + increment (link value)
- pc_valid  output  1  pc is a valid fetch request
- epc  output  XLEN  saved exception PC
- trap_taken  output  1  one-cycle pulse on trap entry
- trap_cause  output  2  0=none, 1=external trap_req, 2=misaligned target
- halted  output  1  FSM in HALT

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. Reset values: pc=RESET_VECTOR, epc=0, trap_taken=0, trap_cause=0, halted=0, pc_valid=0, FSM=BOOT.
- FSM states BOOT, RUN, HALT:
  - BOOT: pc_valid=0 for exactly one cycle after reset release, then RUN. pc is not updated in BOOT.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1, pc held. resume moves to RUN on the next edge. Inputs other than resume and rst_n are ignored in HALT.
  - RUN->HALT on halt_req, evaluated at lowest priority. Trap, mret and redirect in the same cycle are applied first; the FSM then enters HALT with the updated pc.
- Next-PC priority in RUN, highest first, all registered at the next posedge (latency 1):
  1. trap_req: pc<=TRAP_VECTOR, epc<=pc, trap_cause<=1, trap_taken<=1.
  2. redirect_valid with misaligned target (target[1:0]!=0): pc<=TRAP_VECTOR, epc<=pc, trap_cause<=2, trap_taken<=1.
  3. mret: pc<=epc.
  4. redirect_valid (aligned): pc<=redirect_target.
  5. stall or !fetch_ready: pc held.
  6. otherwise: pc<=pc_plus.
- Stall and fetch_ready do not block items 1-4. Redirects, traps and mret are never lost due to backpressure.
- trap_taken is a single-cycle pulse. trap_cause keeps its last value until the next trap.
- epc is written only on trap entry.
- Arithmetic: pc_plus = pc + 4, combinational, modulo 2^XLEN. Wrap from all-ones-minus-3 to 0 is legal and silent.
- Simultaneous trap_req and mret: trap wins; epc gets the current pc, not the mret target.
- rst_n asserted mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: PC_GEN_C_EXT_EN (RVC support).
- Defined:
  - Adds input port instr_is_16 (1 bit).
  - pc_plus = pc + 2 when instr_is_16=1, else pc + 4.
  - Misalignment check uses redirect_target[0] only.
- Undefined:
  - instr_is_16 port absent.
  - Increment is always 4.
  - Misalignment check uses target[1:0].

Test Plan:
- Reset/boot, RESET_VECTOR=0x80: hold rst_n=0, release, run 3 free cycles -> pc=0x80 with pc_valid=0 for 1 cycle, then 0x80 (valid), 0x84, 0x88.
- Stall and backpressure: stall=1 for 2 cycles at pc=0x10 -> pc stays 0x10. Then fetch_ready=0 with redirect_valid=1, target=0x200 -> pc=0x200 next cycle.
- Misaligned branch: at pc=0x40, redirect_target=0x102 -> pc=0x100, epc=0x40, trap_cause=2, trap_taken high for exactly 1 cycle. Then mret -> pc=0x40.
- Priority: trap_req, mret and redirect(0x300) all asserted at pc=0x20 -> pc=0x100, epc=0x20, trap_cause=1.
- Halt/wrap, XLEN=8: run from pc=0xFC -> next pc=0x00. halt_req -> halted=1, pc_valid=0, pc frozen for 5 cycles. resume -> increments resume from the held value.
- With PC_GEN_C_EXT_EN: instr_is_16=1 at pc=0x10 -> 0x12. redirect_target=0x22 is accepted (no trap). redirect_target=0x23 -> trap_cause=2.

Source files
------------

// File: rtl/pc_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_gen_if : control-side and fetch-side signals of the PC generator        |
// | Revision  : 1.0  initial release (instr_is_16 present with PC_GEN_C_EXT_EN)|
// +----------------------------------------------------------------------------+
interface pc_gen_if #(
  parameter int XLEN = 32
);
`ifdef PC_GEN_C_EXT_EN
  logic            instr_is_16;
`endif
  logic            fetch_ready;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            mret;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic            trap_taken;
  logic [1:0]      trap_cause;
  logic            halted;

  // master drives control requests, slave is the PC generator
  modport master (
`ifdef PC_GEN_C_EXT_EN
    output instr_is_16,
`endif
    output fetch_ready, stall, redirect_valid, redirect_target,
    output trap_req, mret, halt_req, resume,
    input  pc, pc_plus, pc_valid, epc, trap_taken, trap_cause, halted
  );

  modport slave (
`ifdef PC_GEN_C_EXT_EN
    input  instr_is_16,
`endif
    input  fetch_ready, stall, redirect_valid, redirect_target,
    input  trap_req, mret, halt_req, resume,
    output pc, pc_plus, pc_valid, epc, trap_taken, trap_cause, halted
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_gen   : program-counter generator with redirect, trap/mret and halt FSM |
// | Option   : PC_GEN_C_EXT_EN enables RVC (+2 increment, 2-byte alignment)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  pc_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] w_epc_nxt;
  logic [1:0]      r_cause;
  logic [1:0]      w_cause_nxt;
  logic            r_taken;
  logic            w_taken_nxt;
  logic [XLEN-1:0] w_inc;
  logic [XLEN-1:0] w_pc_plus;
  logic            w_misaligned;

`ifdef PC_GEN_C_EXT_EN
  assign w_inc        = bus.instr_is_16 ? XLEN'(2) : XLEN'(4);
  assign w_misaligned = bus.redirect_target[0];
`else
  assign w_inc        = XLEN'(4);
  assign w_misaligned = |bus.redirect_target[1:0];
`endif

  // modulo 2^XLEN: wrap past all-ones is intentional
  assign w_pc_plus = r_pc + w_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_cause <= 2'd0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
      r_cause <= w_cause_nxt;
      r_taken <= w_taken_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_cause_nxt = r_cause;
    w_taken_nxt = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        // control-flow changes are never gated by stall or fetch backpressure
        if (bus.trap_req) begin
          w_pc_nxt    = TRAP_VECTOR;
          w_epc_nxt   = r_pc;
          w_cause_nxt = 2'd1;
          w_taken_nxt = 1'b1;
        end else if (bus.redirect_valid && w_misaligned) begin
          w_pc_nxt    = TRAP_VECTOR;
          w_epc_nxt   = r_pc;
          w_cause_nxt = 2'd2;
          w_taken_nxt = 1'b1;
        end else if (bus.mret) begin
          w_pc_nxt = r_epc;
        end else if (bus.redirect_valid) begin
          w_pc_nxt = bus.redirect_target;
        end else if (!bus.stall && bus.fetch_ready) begin
          w_pc_nxt = w_pc_plus;
        end
        // halt is taken after this cycle's pc update has been applied
        if (bus.halt_req) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  assign bus.pc         = r_pc;
  assign bus.pc_plus    = w_pc_plus;
  assign bus.pc_valid   = (r_state == ST_RUN);
  assign bus.halted     = (r_state == ST_HALT);
  assign bus.epc        = r_epc;
  assign bus.trap_taken = r_taken;
  assign bus.trap_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_gen : directed scoreboard bench, 32-bit instance and 8-bit instance  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_gen_if #(.XLEN(32)) bus_a ();
  pc_gen_if #(.XLEN(8))  bus_b ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  pc_gen #(.XLEN(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h40)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    int          cyc;
    bit          inst;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [31:0] epc;
    logic        taken;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic [31:0] m_inc;
  logic [7:0]  m_pb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input bit inst, input int tag, input logic [31:0] p, input logic v,
                      input logic h, input logic [31:0] e, input logic tk, input logic [1:0] cs);
    exp_t x;
    x.cyc = tag; x.inst = inst; x.pc = p; x.valid = v; x.halted = h;
    x.epc = e; x.taken = tk; x.cause = cs;
    sb.push_back(x);
  endtask

  // monitor: pops every expectation due this cycle and compares it with the DUT
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      if (m_e.cyc != cyc) begin
        chk("stale_expectation", 32'(cyc), 32'(m_e.cyc));
      end else if (!m_e.inst) begin
`ifdef PC_GEN_C_EXT_EN
        m_inc = bus_a.instr_is_16 ? 32'd2 : 32'd4;
`else
        m_inc = 32'd4;
`endif
        chk("a_pc",         bus_a.pc,                m_e.pc);
        chk("a_pc_plus",    bus_a.pc_plus,           m_e.pc + m_inc);
        chk("a_pc_valid",   32'(bus_a.pc_valid),     32'(m_e.valid));
        chk("a_halted",     32'(bus_a.halted),       32'(m_e.halted));
        chk("a_epc",        bus_a.epc,               m_e.epc);
        chk("a_trap_taken", 32'(bus_a.trap_taken),   32'(m_e.taken));
        chk("a_trap_cause", 32'(bus_a.trap_cause),   32'(m_e.cause));
      end else begin
        m_pb = m_e.pc[7:0] + 8'd4;
        chk("b_pc",         32'(bus_b.pc),           m_e.pc);
        chk("b_pc_plus",    32'(bus_b.pc_plus),      32'(m_pb));
        chk("b_pc_valid",   32'(bus_b.pc_valid),     32'(m_e.valid));
        chk("b_halted",     32'(bus_b.halted),       32'(m_e.halted));
        chk("b_epc",        32'(bus_b.epc),          m_e.epc);
        chk("b_trap_taken", 32'(bus_b.trap_taken),   32'(m_e.taken));
        chk("b_trap_cause", 32'(bus_b.trap_cause),   32'(m_e.cause));
      end
    end
  end

  task automatic idle_a();
    bus_a.fetch_ready = 1'b1; bus_a.stall = 1'b0; bus_a.redirect_valid = 1'b0;
    bus_a.redirect_target = '0; bus_a.trap_req = 1'b0; bus_a.mret = 1'b0;
    bus_a.halt_req = 1'b0; bus_a.resume = 1'b0;
`ifdef PC_GEN_C_EXT_EN
    bus_a.instr_is_16 = 1'b0;
`endif
  endtask

  task automatic idle_b();
    bus_b.fetch_ready = 1'b1; bus_b.stall = 1'b0; bus_b.redirect_valid = 1'b0;
    bus_b.redirect_target = '0; bus_b.trap_req = 1'b0; bus_b.mret = 1'b0;
    bus_b.halt_req = 1'b0; bus_b.resume = 1'b0;
`ifdef PC_GEN_C_EXT_EN
    bus_b.instr_is_16 = 1'b0;
`endif
  endtask

  // inputs already applied; expectation is the state after the next edge
  task automatic step_a(input logic [31:0] p, input logic v, input logic h,
                        input logic [31:0] e, input logic tk, input logic [1:0] cs);
    push(1'b0, cyc + 1, p, v, h, e, tk, cs);
    @(posedge clk); #1;
    idle_a();
  endtask

  task automatic step_b(input logic [31:0] p, input logic v, input logic h,
                        input logic [31:0] e, input logic tk, input logic [1:0] cs);
    push(1'b1, cyc + 1, p, v, h, e, tk, cs);
    @(posedge clk); #1;
    idle_b();
  endtask

  task automatic redir_a(input logic [31:0] t);
    bus_a.redirect_valid = 1'b1; bus_a.redirect_target = t;
  endtask

  initial begin
    idle_a();
    idle_b();
    @(posedge clk); #1;
    push(1'b0, cyc, 32'h80, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    push(1'b0, cyc, 32'h80, 0, 0, 0, 0, 0);
    rst_a = 1'b1;
    step_a(32'h80, 1, 0, 0, 0, 0);
    step_a(32'h84, 1, 0, 0, 0, 0);
    step_a(32'h88, 1, 0, 0, 0, 0);
    // stall and backpressure
    redir_a(32'h10);                         step_a(32'h10, 1, 0, 0, 0, 0);
    bus_a.stall = 1'b1;                      step_a(32'h10, 1, 0, 0, 0, 0);
    bus_a.stall = 1'b1;                      step_a(32'h10, 1, 0, 0, 0, 0);
    bus_a.fetch_ready = 1'b0; redir_a(32'h200); step_a(32'h200, 1, 0, 0, 0, 0);
    bus_a.fetch_ready = 1'b0;                step_a(32'h200, 1, 0, 0, 0, 0);
    step_a(32'h204, 1, 0, 0, 0, 0);
    // misaligned branch then mret
    redir_a(32'h40);                         step_a(32'h40, 1, 0, 0, 0, 0);
    redir_a(32'h102);                        step_a(32'h100, 1, 0, 32'h40, 1, 2);
    bus_a.mret = 1'b1;                       step_a(32'h40, 1, 0, 32'h40, 0, 2);
    step_a(32'h44, 1, 0, 32'h40, 0, 2);
    // priority
    redir_a(32'h20);                         step_a(32'h20, 1, 0, 32'h40, 0, 2);
    bus_a.trap_req = 1'b1; bus_a.mret = 1'b1; redir_a(32'h300);
    step_a(32'h100, 1, 0, 32'h20, 1, 1);
    bus_a.mret = 1'b1; redir_a(32'h300);     step_a(32'h20, 1, 0, 32'h20, 0, 1);
    bus_a.stall = 1'b1; bus_a.fetch_ready = 1'b0; bus_a.trap_req = 1'b1;
    step_a(32'h100, 1, 0, 32'h20, 1, 1);
    bus_a.mret = 1'b1; bus_a.stall = 1'b1;   step_a(32'h20, 1, 0, 32'h20, 0, 1);
    step_a(32'h24, 1, 0, 32'h20, 0, 1);
    // halt with a same-cycle redirect, inputs ignored while halted
    bus_a.halt_req = 1'b1; redir_a(32'h500); step_a(32'h500, 0, 1, 32'h20, 0, 1);
    for (int i = 0; i < 3; i++) begin
      bus_a.trap_req = 1'b1; bus_a.mret = 1'b1; bus_a.halt_req = 1'b1; redir_a(32'h600);
      step_a(32'h500, 0, 1, 32'h20, 0, 1);
    end
    bus_a.resume = 1'b1;                     step_a(32'h500, 1, 0, 32'h20, 0, 1);
    step_a(32'h504, 1, 0, 32'h20, 0, 1);
    // 32-bit wrap
    redir_a(32'hFFFF_FFFC);                  step_a(32'hFFFF_FFFC, 1, 0, 32'h20, 0, 1);
    step_a(32'h0, 1, 0, 32'h20, 0, 1);
    step_a(32'h4, 1, 0, 32'h20, 0, 1);
    @(posedge clk); #1;
    // asynchronous reset mid-run
    rst_a = 1'b0;
    push(1'b0, cyc, 32'h80, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    push(1'b0, cyc, 32'h80, 0, 0, 0, 0, 0);
    rst_a = 1'b1;
    step_a(32'h80, 1, 0, 0, 0, 0);
`ifdef PC_GEN_C_EXT_EN
    redir_a(32'h10);                         step_a(32'h10, 1, 0, 0, 0, 0);
    bus_a.instr_is_16 = 1'b1;                step_a(32'h12, 1, 0, 0, 0, 0);
    redir_a(32'h22);                         step_a(32'h22, 1, 0, 0, 0, 0);
    redir_a(32'h23);                         step_a(32'h100, 1, 0, 32'h22, 1, 2);
`else
    redir_a(32'h22);                         step_a(32'h100, 1, 0, 32'h80, 1, 2);
    redir_a(32'h81);                         step_a(32'h100, 1, 0, 32'h100, 1, 2);
`endif
    // 8-bit instance: wrap, halt, resume
    push(1'b1, cyc, 32'hF8, 0, 0, 0, 0, 0);
    rst_b = 1'b1;
    step_b(32'hF8, 1, 0, 0, 0, 0);
    step_b(32'hFC, 1, 0, 0, 0, 0);
    step_b(32'h00, 1, 0, 0, 0, 0);
    step_b(32'h04, 1, 0, 0, 0, 0);
    bus_b.halt_req = 1'b1;                   step_b(32'h08, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus_b.trap_req = 1'b1; bus_b.redirect_valid = 1'b1; bus_b.redirect_target = 8'h60;
      step_b(32'h08, 0, 1, 0, 0, 0);
    end
    bus_b.resume = 1'b1;                     step_b(32'h08, 1, 0, 0, 0, 0);
    step_b(32'h0C, 1, 0, 0, 0, 0);
    step_b(32'h10, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
